// File: rtl/fir_inverse_iir_pkg.sv
// ============================================================================
// Module : fir_inverse_iir_pkg
// Brief  : Shared sample-width constants, FSM encodings and saturator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fir_inverse_iir_pkg;

  localparam int SAMPLE_W = 16;
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 16'sh7fff;
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [63:0] v);
    if (v > 64'sd32767) begin
      return SAMPLE_MAX;
    end else if (v < -64'sd32768) begin
      return SAMPLE_MIN;
    end else begin
      return v[SAMPLE_W-1:0];
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_inverse_iir_mac_unit.sv
// ============================================================================
// Module : fir_inverse_iir_mac_unit
// Brief  : Registered accumulator with load and multiply-subtract step.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_inverse_iir_mac_unit
  import fir_inverse_iir_pkg::*;
#(
  parameter int COEF_W = 16,
  parameter int ACC_W  = 44
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_load,
  input  logic                     i_en,
  input  logic signed [ACC_W-1:0]  i_load_val,
  input  logic signed [COEF_W-1:0] i_coef,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [COEF_W+SAMPLE_W-1:0] w_prod;
  logic signed [ACC_W-1:0]           w_prod_ext;
  logic signed [ACC_W-1:0]           r_acc;

  assign w_prod     = i_coef * i_sample;
  assign w_prod_ext = ACC_W'(w_prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= i_load_val;
    end else if (i_en) begin
      r_acc <= r_acc - w_prod_ext;
    end
  end

  assign o_acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/fir_inverse_iir.sv
// ============================================================================
// Module : fir_inverse_iir
// Brief  : All-pole inverse of the FIR path, one shared MAC, valid/ready I/O.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_inverse_iir
  import fir_inverse_iir_pkg::*;
#(
  parameter int TAPS   = 4,
  parameter int COEF_W = 16,
  parameter int FRAC   = 8,
  parameter logic [(TAPS-1)*COEF_W-1:0] COEFS = {16'sd0, 16'sd0, 16'sd256}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [SAMPLE_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [SAMPLE_W-1:0] out_data
);

  localparam int ACC_W = SAMPLE_W + COEF_W + FRAC + 4;
  localparam int K_W   = $clog2(TAPS + 1);

  state_t                      r_state;
  logic [K_W-1:0]              r_k;
  logic signed [SAMPLE_W-1:0]  r_hist [TAPS-1];
  logic signed [COEF_W-1:0]    w_coef_tab [TAPS-1];
  logic signed [COEF_W-1:0]    w_coef;
  logic signed [SAMPLE_W-1:0]  w_sample;
  logic signed [ACC_W-1:0]     w_load_val;
  logic signed [ACC_W-1:0]     w_acc;
  logic signed [ACC_W-1:0]     w_scaled;
  logic                        w_load;
  logic                        w_mac_en;

  generate
    for (genvar g = 0; g < TAPS - 1; g++) begin : g_coef
      assign w_coef_tab[g] = COEFS[g*COEF_W +: COEF_W];
    end
  endgenerate

  // Tap k pairs h[k] with x[n-k], which lives in r_hist[k-1].
  always_comb begin
    w_coef   = '0;
    w_sample = '0;
    for (int i = 0; i < TAPS - 1; i++) begin
      if (r_k == K_W'(i + 1)) begin
        w_coef   = w_coef_tab[i];
        w_sample = r_hist[i];
      end
    end
  end

  assign w_load_val = ACC_W'(in_data) <<< FRAC;
  assign w_load     = (r_state == ST_IDLE) && in_valid && !clr;
  assign w_mac_en   = (r_state == ST_MAC) && (r_k <= K_W'(TAPS - 1));
  assign w_scaled   = w_acc >>> FRAC;
  assign in_ready   = (r_state == ST_IDLE);

  fir_inverse_iir_mac_unit #(
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (clr),
    .i_load     (w_load),
    .i_en       (w_mac_en),
    .i_load_val (w_load_val),
    .i_coef     (w_coef),
    .i_sample   (w_sample),
    .o_acc      (w_acc)
  );

  // After the last tap (k=TAPS-1) one extra MAC-state cycle lets the
  // accumulator settle before it is scaled and saturated into out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_k       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < TAPS - 1; i++) begin
        r_hist[i] <= '0;
      end
    end else if (clr) begin
      r_state   <= ST_IDLE;
      r_k       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < TAPS - 1; i++) begin
        r_hist[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_k     <= K_W'(1);
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (r_k == K_W'(TAPS)) begin
            out_data  <= sat16(64'(w_scaled));
            out_valid <= 1'b1;
            r_k       <= '0;
            r_state   <= ST_OUT;
          end else begin
            r_k <= r_k + K_W'(1);
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            for (int i = TAPS - 2; i > 0; i--) begin
              r_hist[i] <= r_hist[i-1];
            end
            r_hist[0] <= out_data;
            out_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_inverse_iir.sv
// ============================================================================
// Module : tb_fir_inverse_iir
// Brief  : Directed scoreboard bench for three coefficient sets of the inverse filter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fir_inverse_iir;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic               in_valid  [3];
  logic               in_ready  [3];
  logic signed [15:0] in_data   [3];
  logic               out_valid [3];
  logic               out_ready [3];
  logic signed [15:0] out_data  [3];
  logic               clr       [3];

  int n_checks = 0;
  int n_errors = 0;
  int sb[$];
  int mh[3][3];
  int mcoef[3][3];

  always #5 clk = ~clk;

  fir_inverse_iir u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0])
  );

  fir_inverse_iir #(.COEFS({16'sd0, 16'sd0, 16'sd128})) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1])
  );

  fir_inverse_iir #(.COEFS({16'sd0, 16'sd0, -16'sd256})) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2])
  );

  task automatic check(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: x = floor((y*2^8 - sum h[k]*x[n-k]) / 2^8), clamped to 16 bits.
  function automatic int model(int d, int y);
    longint acc;
    acc = longint'(y) * 256;
    for (int k = 0; k < 3; k++) acc -= longint'(mcoef[d][k]) * longint'(mh[d][k]);
    acc = acc >>> 8;
    if (acc > 32767) return 32767;
    if (acc < -32768) return -32768;
    return int'(acc);
  endfunction

  task automatic clear_model(int d);
    for (int k = 0; k < 3; k++) mh[d][k] = 0;
  endtask

  task automatic issue(int d, int y, bit keep);
    int t;
    int x;
    t = 0;
    @(negedge clk);
    while (in_ready[d] !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", in_ready[d], 1);
    in_data[d]  = 16'(y);
    in_valid[d] = 1'b1;
    if (keep) begin
      x = model(d, y);
      sb.push_back(x);
      mh[d][2] = mh[d][1];
      mh[d][1] = mh[d][0];
      mh[d][0] = x;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  task automatic collect(int d);
    int lat;
    int exp;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) check("busy_in_ready", in_ready[d], 0);
      if (out_valid[d] === 1'b1) break;
    end
    check("latency", lat, 4);
    exp = (sb.size() > 0) ? sb.pop_front() : 32'h7fff_dead;
    check("out_data", out_data[d], exp);
  endtask

  task automatic finish_hs(int d);
    @(posedge clk);
    @(negedge clk);
    check("out_valid_drop", out_valid[d], 0);
    check("in_ready_back", in_ready[d], 1);
  endtask

  task automatic clr_pulse(int d);
    @(negedge clk);
    clr[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr[d] = 1'b0;
    clear_model(d);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int seq1[5];
    logic signed [15:0] held;
    seq1 = '{1, 3, 5, 7, 9};
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b1; clr[d] = 1'b0;
      clear_model(d);
      mcoef[d][1] = 0; mcoef[d][2] = 0;
    end
    mcoef[0][0] = 256; mcoef[1][0] = 128; mcoef[2][0] = -256;

    // Reset state
    #1;
    check("rst_out_valid", out_valid[0], 0);
    check("rst_out_data", out_data[0], 0);
    check("rst_in_ready", in_ready[0], 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Default h1=1.0
    foreach (seq1[i]) begin issue(0, seq1[i], 1); collect(0); finish_hs(0); end

    // h1=0.5 impulse
    issue(1, 256, 1); collect(1); finish_hs(1);
    for (int i = 0; i < 3; i++) begin issue(1, 0, 1); collect(1); finish_hs(1); end

    // h1=-1.0 saturation both rails
    issue(2, 32767, 1); collect(2); finish_hs(2);
    issue(2, 32767, 1); collect(2); finish_hs(2);
    clr_pulse(2);
    issue(2, -32768, 1); collect(2); finish_hs(2);
    issue(2, -32768, 1); collect(2); finish_hs(2);

    // Output stall holds everything
    out_ready[0] = 1'b0;
    issue(0, 10, 1); collect(0);
    held = out_data[0];
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", out_valid[0], 1);
      check("stall_data", out_data[0], held);
      check("stall_in_ready", in_ready[0], 0);
    end
    out_ready[0] = 1'b1;
    finish_hs(0);
    issue(0, 7, 1); collect(0); finish_hs(0);

    // clr aborts an in-flight sample
    clr_pulse(0);
    issue(0, 1, 1); collect(0); finish_hs(0);
    issue(0, 3, 1); collect(0); finish_hs(0);
    issue(0, 5, 0);
    @(posedge clk);
    @(negedge clk);
    clr[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr[0] = 1'b0;
    clear_model(0);
    check("clr_out_valid", out_valid[0], 0);
    check("clr_in_ready", in_ready[0], 1);

    // clr beats in_valid in the same cycle
    in_valid[0] = 1'b1; in_data[0] = 16'sd99; clr[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0; clr[0] = 1'b0;
    check("clr_prio_in_ready", in_ready[0], 1);
    repeat (6) begin
      @(negedge clk);
      check("no_spurious_out", out_valid[0], 0);
    end
    issue(0, 1, 1); collect(0); finish_hs(0);

    // Async reset mid-MAC
    issue(0, 1, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid[0], 0);
    check("arst_out_data", out_data[0], 0);
    check("arst_in_ready", in_ready[0], 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) clear_model(d);
    foreach (seq1[i]) begin issue(0, seq1[i], 1); collect(0); finish_hs(0); end

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
